alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle successor to the single-cycle ALU in the Yinger execute stage.
//  Keeps the 4-bit ALU control codes; adds signed compare, shifts and iterative unsigned multiply/divide.
//  Uses a valid/ready handshake on both sides, so the pipeline stalls while a mul/div iterates.
//  Result and zero flag are registered.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=8, power of two)
//  CTW      4  width of alu_ct
//  SHW      5  shift-amount bits used from alu_src2; must equal log2(WIDTH)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operation offered on alu_ct/alu_src1/alu_src2
//  in_ready   out  1      block accepts the operation this cycle
//  alu_ct     in   CTW    operation code
//  alu_src1   in   WIDTH  operand A
//  alu_src2   in   WIDTH  operand B
//  out_valid  out  1      alu_res/alu_zero hold a valid result
//  out_ready  in   1      consumer takes the result this cycle
//  alu_res    out  WIDTH  result
//  alu_zero   out  1      1 when alu_res == 0 (registered with alu_res)
//  alu_busy   out  1      mul/div iteration in progress
// BEHAVIOUR
//  Reset: synchronous, active-high (rst). State=IDLE, alu_res=0, alu_zero=1, out_valid=0, alu_busy=0, in_ready=1.
//  Accept: on in_valid && in_ready. Operands and op are latched; inputs are ignored at all other times.
//  Op codes:
//    0000 AND     0001 OR      0010 ADD (wraps mod 2^WIDTH)   0011 XOR
//    0100 NOR     0110 SUB (wraps)                           0111 SLT (signed, result 0/1)
//    1000 SLTU    1001 SLL     1010 SRL     1011 SRA  (shift amount = src2[SHW-1:0])
//    1100 MULLO (low WIDTH of unsigned A*B)   1101 MULHI (high WIDTH)
//    1110 DIVU    1111 REMU
//  Undefined code 0101: completes as a single-cycle op with alu_res=0, alu_zero=1.
//  FSM: IDLE -> (accept single-cycle op) -> DONE
//       IDLE -> (accept mul/div op) -> BUSY
//       BUSY -> after exactly WIDTH iteration cycles -> DONE
//       DONE -> (out_ready) -> IDLE, or straight to DONE/BUSY if a new op is accepted in the same cycle
//  Latency, accept in cycle N:
//    single-cycle op: out_valid in N+1
//    mul/div: out_valid in N+1+WIDTH; alu_busy high in N+1 .. N+WIDTH
//  in_ready = (state==IDLE) || (state==DONE && out_ready); back-to-back single-cycle ops sustain 1 op/cycle.
//  Output hold: alu_res, alu_zero and out_valid stay stable while out_valid && !out_ready.
//  Divide by zero: DIVU gives all-ones; REMU gives src1; takes the full WIDTH cycles, no exception.
//  Mul: radix-2 shift-add over a 2*WIDTH accumulator.
//  Div: restoring, one quotient bit per cycle, MSB first.
//  rst while BUSY or DONE: operation discarded, nothing emitted, reset values above in the next cycle.
//  Same cycle as out_ready && in_valid in DONE: the old result is consumed and the new op is accepted; no bubble.
// STRUCTURE
//  Package yinger_alu_pkg: localparams for all 16 ALU_* op codes, fsm state enum (IDLE/BUSY/DONE),
//  and an is_multicycle(op) function. Shared with the ALU control decoder.
//  Sub-module alu_mc_iter: iterative mul/div datapath.
//    Ports: clk, rst, start, op[1:0], a, b, done, hi, lo. Owns the iteration counter and the accumulator.
//  Top: operand latches, single-cycle result mux, FSM, handshake and output registers.
// TESTING (WIDTH=32)
//  1 ADD 0xFFFFFFFF+1 -> alu_res=0, alu_zero=1, out_valid one cycle after accept.
//    SLT 0xFFFFFFFF,1 -> 1; SLTU with the same operands -> 0.
//  2 SRA 0x80000000 by 4 -> 0xF8000000; SRL -> 0x08000000; src2=0x24 shifts by 4 (low 5 bits only).
//  3 MULHI 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE and MULLO -> 0x00000001.
//    Each has out_valid exactly 33 cycles after accept; in_ready=0 throughout BUSY.
//  4 DIVU 100/7 -> 14, REMU -> 2. DIVU x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
//  5 out_ready held 0 for 5 cycles after a result -> alu_res stable, in_ready=0.
//    Then out_ready=1 with a new op offered -> consumed and accepted in the same cycle.
//  6 rst pulsed 10 cycles into a DIVU -> next cycle out_valid=0, alu_res=0, alu_busy=0, in_ready=1.
//    A following ADD 2+3 returns 5.

Source files
------------

// File: rtl/yinger_alu_pkg.sv
// Shared definitions for the Yinger execute-stage ALU: control codes, FSM states
// and the multi-cycle op classifier used by both the ALU and its control decoder.
package yinger_alu_pkg;

  localparam int ALU_CTW = 4;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_NOR   = 4'b0100;
  localparam logic [3:0] ALU_UNDEF = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLTU  = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b1001;
  localparam logic [3:0] ALU_SRL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;
  localparam logic [3:0] ALU_MULLO = 4'b1100;
  localparam logic [3:0] ALU_MULHI = 4'b1101;
  localparam logic [3:0] ALU_DIVU  = 4'b1110;
  localparam logic [3:0] ALU_REMU  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Mul/div codes occupy the top quarter of the code space.
  function automatic logic is_multicycle(input logic [3:0] op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Iterative unsigned multiply/divide datapath: radix-2 shift-add multiply and
// restoring divide, both running WIDTH cycles over a 2*WIDTH accumulator.
module alu_mc_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   r_m;
  logic               r_div;
  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic               w_unused_op;

  // Low op bit only selects hi/lo in the top; the datapath is identical.
  assign w_unused_op = op[0];

  always_comb begin
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_m} : '0);
    w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_m};
    w_acc_next = r_acc;
    if (r_div) begin
      // Accumulator is {remainder, dividend/quotient}; a clear borrow means the trial fits.
      if (!w_trial[WIDTH])
        w_acc_next = {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else
        w_acc_next = {r_acc[2*WIDTH-2:0], 1'b0};
    end else begin
      w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    end
  end

  // hi/lo present the post-iteration value so the top can register it on done.
  assign done = r_busy && (r_cnt == CW'(1));
  assign hi   = w_acc_next[2*WIDTH-1:WIDTH];
  assign lo   = w_acc_next[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc  <= '0;
      r_m    <= '0;
      r_div  <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_cnt  <= CW'(WIDTH);
      r_div  <= op[1];
      r_m    <= op[1] ? b : a;
      r_acc  <= {{WIDTH{1'b0}}, (op[1] ? a : b)};
    end else if (r_busy) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1))
        r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake on both sides; single-cycle ops
// complete next cycle, mul/div iterate in alu_mc_iter. Result and zero are registered.
module alu_mc
  import yinger_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CTW   = 4,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CTW-1:0]   alu_ct,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_res,
  output logic             alu_zero,
  output logic             alu_busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic             r_sel_hi;
  logic             w_accept;
  logic             w_is_mc;
  logic             w_iter_start;
  logic             w_iter_done;
  logic [WIDTH-1:0] w_iter_hi;
  logic [WIDTH-1:0] w_iter_lo;
  logic [WIDTH-1:0] w_iter_res;
  logic [WIDTH-1:0] w_single;
  logic [SHW-1:0]   w_shamt;

  assign in_ready     = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign w_accept     = in_valid && in_ready;
  assign w_is_mc      = is_multicycle(alu_ct);
  assign w_iter_start = w_accept && w_is_mc;
  assign w_shamt      = alu_src2[SHW-1:0];
  assign w_iter_res   = r_sel_hi ? w_iter_hi : w_iter_lo;

  assign out_valid = (r_state == DONE);
  assign alu_busy  = (r_state == BUSY);
  assign alu_res   = r_res;
  assign alu_zero  = r_zero;

  alu_mc_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .start(w_iter_start),
    .op   (alu_ct[1:0]),
    .a    (alu_src1),
    .b    (alu_src2),
    .done (w_iter_done),
    .hi   (w_iter_hi),
    .lo   (w_iter_lo)
  );

  // Undefined and mul/div codes fall to zero here; mul/div results come from the iterator.
  always_comb begin
    w_single = '0;
    case (alu_ct)
      ALU_AND:  w_single = alu_src1 & alu_src2;
      ALU_OR:   w_single = alu_src1 | alu_src2;
      ALU_ADD:  w_single = alu_src1 + alu_src2;
      ALU_XOR:  w_single = alu_src1 ^ alu_src2;
      ALU_NOR:  w_single = ~(alu_src1 | alu_src2);
      ALU_SUB:  w_single = alu_src1 - alu_src2;
      ALU_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(alu_src1) < $signed(alu_src2))};
      ALU_SLTU: w_single = {{(WIDTH-1){1'b0}}, (alu_src1 < alu_src2)};
      ALU_SLL:  w_single = alu_src1 << w_shamt;
      ALU_SRL:  w_single = alu_src1 >> w_shamt;
      ALU_SRA:  w_single = $unsigned($signed(alu_src1) >>> w_shamt);
      default:  w_single = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept)
          w_state_next = w_is_mc ? BUSY : DONE;
      end
      BUSY: begin
        if (w_iter_done)
          w_state_next = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (w_accept)
            w_state_next = w_is_mc ? BUSY : DONE;
          else
            w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_res    <= '0;
      r_zero   <= 1'b1;
      r_sel_hi <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept && !w_is_mc) begin
        r_res  <= w_single;
        r_zero <= (w_single == '0);
      end else if (w_iter_start) begin
        r_sel_hi <= alu_ct[0];
      end else if ((r_state == BUSY) && w_iter_done) begin
        r_res  <= w_iter_res;
        r_zero <= (w_iter_res == '0);
      end
    end
  end

endmodule
